square_sweep_ctl: RTL and testbench
===================================

Name: square_sweep_ctl

Overview:
- Sweep control unit for one APU square channel. It sits on the consumer side of SQUARE_BarrelShifter.
- Holds the 11-bit frequency register and the sweep register ($4001/$4005), and drives the shifter's frequency and shift-amount inputs.
- Takes the shifted value back and forms the sweep target with an add or subtract.
- On half-frame ticks, writes the target back into the frequency register under divider control, and generates the sweep mute signal for the channel output.

Parameters:
- CHANNEL, 0: 0 = square 1 (ones'-complement negate); 1 = square 2 (two's-complement negate).
- FREQ_W, 11: frequency register width. It is fixed at 11 to match the shifter and exists only for readability.

Ports:
- CLK  in  1  APU clock.
- n_RES  in  1  asynchronous active-low reset.
- HALF_FRAME  in  1  one-cycle half-frame tick from the frame counter.
- SWEEP_WR  in  1  write strobe for the sweep register.
- FREQ_LO_WR  in  1  write strobe for frequency bits [7:0].
- FREQ_HI_WR  in  1  write strobe for frequency bits [10:8].
- DB  in  8  CPU data bus, sampled on any write strobe.
- S  in  11  shifted frequency returned by the barrel shifter.
- FREQ  out  11  current frequency register; also the shifter input.
- SR  out  3  sweep shift amount; also the shifter input.
- SWEEP_MUTE  out  1  channel mute request.
- SWEEP_TICK  out  1  one-cycle pulse when FREQ is rewritten by the sweep.
- SHIFT_ERR  out  1  sticky shifter-check flag (see Optional Feature).

Behaviour:
- Reset (n_RES low, asynchronous):
  - FREQ=0, SR=0, EN=0, NEG=0, PERIOD=0.
  - divider=0, reload=0.
  - SWEEP_TICK=0, SHIFT_ERR=0.
  - SWEEP_MUTE=1, because FREQ<8.
- Sweep register on SWEEP_WR:
  - EN=DB[7], PERIOD=DB[6:4], NEG=DB[3], SR=DB[2:0].
  - Sets reload=1.
- Frequency writes:
  - FREQ_LO_WR loads FREQ[7:0]=DB.
  - FREQ_HI_WR loads FREQ[10:8]=DB[2:0].
- S is combinational from the shifter in the same cycle (expected S = FREQ>>SR). The block has no internal shifter.
- Target, 12-bit T:
  - NEG=0: T = {0,FREQ} + {0,S}.
  - NEG=1, CHANNEL=0: T = FREQ + ~S, 11-bit wrap, i.e. FREQ-S-1.
  - NEG=1, CHANNEL=1: T = FREQ - S, 11-bit wrap.
  - T[11] is meaningful only when NEG=0.
- SWEEP_MUTE is combinational: (FREQ < 8) | (~NEG & T[11]). It is independent of EN.
- On a cycle with HALF_FRAME=1:
  - If divider==0 & EN & SR!=0 & ~SWEEP_MUTE: FREQ <= T[10:0] and SWEEP_TICK=1 on the next cycle.
  - If divider==0 or reload: divider <= PERIOD and reload <= 0.
  - Otherwise divider <= divider-1.
- Simultaneous events:
  - A CPU frequency write in the same cycle as a sweep update wins for the written byte. The sweep result is discarded for that byte only; the other byte takes T.
  - SWEEP_WR together with HALF_FRAME: the half-frame uses the pre-write EN/NEG/SR/PERIOD values. Reload ends at 1 (the write wins over the clear).
- No saturation: a negate result below 0 wraps at 11 bits. Square 1 with FREQ=0, SR=1 and NEG=1 is blocked anyway, because mute is set when FREQ<8.
- Reset mid-operation clears the divider and reload immediately. No pending update survives reset.

Optional Feature:
- Macro: SQUARE_SWEEP_SHIFTER_CHECK_EN.
- With the macro defined:
  - The block computes FREQ>>SR internally every cycle and compares it with S.
  - On a mismatch, SHIFT_ERR is set and stays at 1 until reset.
  - A simulation $display is issued with FREQ, SR and S.
- Without the macro: SHIFT_ERR is tied to 0 and no compare logic is built.

Test Plan:
- Reset, then release n_RES with no writes: FREQ=0, SR=0, SWEEP_MUTE=1, SWEEP_TICK=0; 10 HALF_FRAME pulses leave FREQ=0.
- FREQ=0x100, sweep write 0x81 (EN, PERIOD=0, NEG=0, SR=1), one HALF_FRAME: FREQ=0x180, SWEEP_TICK pulses once; next HALF_FRAME gives FREQ=0x240.
- FREQ=0x100, sweep write 0x89 (negate, SR=1), one HALF_FRAME: CHANNEL=0 gives FREQ=0x07F; CHANNEL=1 gives FREQ=0x080.
- FREQ=0x600, sweep write 0x81: T=0x900, SWEEP_MUTE=1, HALF_FRAME leaves FREQ=0x600. Separately, FREQ=0x007 with any sweep gives SWEEP_MUTE=1.
- Divider timing: FREQ=0x100, sweep write 0xA1 (PERIOD=2, SR=1), then 7 HALF_FRAME pulses: updates only on pulses 1, 4 and 7; final FREQ=0x100→0x180→0x240→0x360.
- Collisions:
  - FREQ_LO_WR with DB=0x55 in the same cycle as an update that would give 0x180: FREQ=0x155.
  - With the check macro defined, force S=0x000 while FREQ=0x100, SR=1: SHIFT_ERR=1 and stays 1 until n_RES is asserted.

Source files
------------

// File: rtl/square_sweep_ctl.sv
`default_nettype none
// ============================================================================
// Module   : square_sweep_ctl
// Brief    : APU square-channel sweep unit: frequency/sweep registers, sweep
//            target, half-frame divider and mute; optional shifter self-check
//            enabled by the macro SQUARE_SWEEP_SHIFTER_CHECK_EN.
// Revision : 1.0
// ============================================================================
module square_sweep_ctl #(
    parameter int CHANNEL = 0,
    parameter int FREQ_W  = 11
) (
    input  logic              CLK,
    input  logic              n_RES,
    input  logic              HALF_FRAME,
    input  logic              SWEEP_WR,
    input  logic              FREQ_LO_WR,
    input  logic              FREQ_HI_WR,
    input  logic [7:0]        DB,
    input  logic [FREQ_W-1:0] S,
    output logic [FREQ_W-1:0] FREQ,
    output logic [2:0]        SR,
    output logic              SWEEP_MUTE,
    output logic              SWEEP_TICK,
    output logic              SHIFT_ERR
);

    localparam logic [FREQ_W-1:0] MUTE_FLOOR = FREQ_W'(8);

    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [2:0]        sr_q;
    logic [2:0]        period_q;
    logic [2:0]        div_q, div_d;
    logic              en_q;
    logic              neg_q;
    logic              reload_q, reload_d;
    logic              tick_q;

    logic [FREQ_W:0]   w_target;
    logic              w_mute;
    logic              w_update;

    // Square 1 negates in ones' complement, so its target lands one lower.
    always_comb begin
        w_target = {1'b0, freq_q} + {1'b0, S};
        if (neg_q) begin
            if (CHANNEL == 0) begin
                w_target = {1'b0, freq_q + ~S};
            end else begin
                w_target = {1'b0, freq_q - S};
            end
        end
    end

    assign w_mute   = (freq_q < MUTE_FLOOR) | (~neg_q & w_target[FREQ_W]);
    assign w_update = HALF_FRAME & (div_q == 3'd0) & en_q & (sr_q != 3'd0) & ~w_mute;

    // A CPU byte write overrides the sweep result for that byte only.
    always_comb begin
        freq_d = freq_q;
        if (w_update) begin
            freq_d = w_target[FREQ_W-1:0];
        end
        if (FREQ_LO_WR) begin
            freq_d[7:0] = DB;
        end
        if (FREQ_HI_WR) begin
            freq_d[FREQ_W-1:8] = DB[FREQ_W-9:0];
        end
    end

    always_comb begin
        div_d    = div_q;
        reload_d = reload_q;
        if (HALF_FRAME) begin
            if ((div_q == 3'd0) || reload_q) begin
                div_d    = period_q;
                reload_d = 1'b0;
            end else begin
                div_d = div_q - 3'd1;
            end
        end
        if (SWEEP_WR) begin
            reload_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            freq_q   <= '0;
            sr_q     <= 3'd0;
            period_q <= 3'd0;
            div_q    <= 3'd0;
            en_q     <= 1'b0;
            neg_q    <= 1'b0;
            reload_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            freq_q   <= freq_d;
            div_q    <= div_d;
            reload_q <= reload_d;
            tick_q   <= w_update;
            if (SWEEP_WR) begin
                en_q     <= DB[7];
                period_q <= DB[6:4];
                neg_q    <= DB[3];
                sr_q     <= DB[2:0];
            end
        end
    end

    assign FREQ       = freq_q;
    assign SR         = sr_q;
    assign SWEEP_MUTE = w_mute;
    assign SWEEP_TICK = tick_q;

`ifdef SQUARE_SWEEP_SHIFTER_CHECK_EN
    logic [FREQ_W-1:0] w_expect_s;
    logic              err_q;

    assign w_expect_s = freq_q >> sr_q;

    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            err_q <= 1'b0;
        end else if (S != w_expect_s) begin
            err_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge CLK) begin
        if (n_RES && (S != w_expect_s) && !err_q) begin
            $display("square_sweep_ctl shifter check: freq=%h sr=%0d s=%h", freq_q, sr_q, S);
        end
    end
`endif

    assign SHIFT_ERR = err_q;
`else
    assign SHIFT_ERR = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_square_sweep_ctl.sv
`default_nettype none
// Bench for square_sweep_ctl: directed vector table, hand sequences and a
// randomized run against a behavioural sweep model.
module tb_square_sweep_ctl;
    localparam int CH = 0;
`ifdef SQUARE_SWEEP_SHIFTER_CHECK_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic        CLK = 1'b0;
    logic        n_RES = 1'b0;
    logic        HALF_FRAME = 1'b0;
    logic        SWEEP_WR = 1'b0;
    logic        FREQ_LO_WR = 1'b0;
    logic        FREQ_HI_WR = 1'b0;
    logic [7:0]  DB = 8'h00;
    logic [10:0] S;
    logic [10:0] FREQ;
    logic [2:0]  SR;
    logic        SWEEP_MUTE;
    logic        SWEEP_TICK;
    logic        SHIFT_ERR;

    logic        force_s = 1'b0;
    logic [10:0] s_force = 11'h000;

    // Barrel shifter stand-in, with an override for the self-check test.
    assign S = force_s ? s_force : (FREQ >> SR);

    square_sweep_ctl #(.CHANNEL(CH), .FREQ_W(11)) dut (
        .CLK        (CLK),
        .n_RES      (n_RES),
        .HALF_FRAME (HALF_FRAME),
        .SWEEP_WR   (SWEEP_WR),
        .FREQ_LO_WR (FREQ_LO_WR),
        .FREQ_HI_WR (FREQ_HI_WR),
        .DB         (DB),
        .S          (S),
        .FREQ       (FREQ),
        .SR         (SR),
        .SWEEP_MUTE (SWEEP_MUTE),
        .SWEEP_TICK (SWEEP_TICK),
        .SHIFT_ERR  (SHIFT_ERR)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_freq, m_sr, m_en, m_neg, m_period, m_div, m_reload, m_tick;

    function automatic int m_mute();
        int shifted;
        shifted = m_freq >> m_sr;
        return ((m_freq < 8) || (m_neg == 0 && (m_freq + shifted) > 2047)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_freq = 0; m_sr = 0; m_en = 0; m_neg = 0; m_period = 0;
        m_div = 0; m_reload = 0; m_tick = 0;
    endtask

    task automatic model_edge(input int hf, input int sw, input int lo, input int hi, input int db);
        int shifted, tgt, nf, upd;
        shifted = m_freq >> m_sr;
        if (m_neg != 0) tgt = (m_freq - shifted - ((CH == 0) ? 1 : 0)) & 'h7FF;
        else            tgt = (m_freq + shifted) & 'h7FF;
        upd = (hf != 0 && m_div == 0 && m_en != 0 && m_sr != 0 && m_mute() == 0) ? 1 : 0;
        nf = (upd != 0) ? tgt : m_freq;
        if (lo != 0) nf = (nf & 'h700) | (db & 'hFF);
        if (hi != 0) nf = (nf & 'h0FF) | ((db & 7) << 8);
        if (hf != 0) begin
            if (m_div == 0 || m_reload != 0) begin
                m_div = m_period;
                m_reload = 0;
            end else begin
                m_div = m_div - 1;
            end
        end
        if (sw != 0) begin
            m_en = (db >> 7) & 1; m_period = (db >> 4) & 7;
            m_neg = (db >> 3) & 1; m_sr = db & 7;
            m_reload = 1;
        end
        m_tick = upd;
        m_freq = nf;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".freq"}, int'(FREQ), m_freq);
        chk({tag, ".sr"}, int'(SR), m_sr);
        chk({tag, ".mute"}, int'(SWEEP_MUTE), m_mute());
        chk({tag, ".tick"}, int'(SWEEP_TICK), m_tick);
        chk({tag, ".shift_err"}, int'(SHIFT_ERR), 0);
    endtask

    task automatic step(input bit hf, input bit sw, input bit lo, input bit hi, input logic [7:0] db);
        @(negedge CLK);
        HALF_FRAME = hf; SWEEP_WR = sw; FREQ_LO_WR = lo; FREQ_HI_WR = hi; DB = db;
        @(posedge CLK);
        model_edge(int'(hf), int'(sw), int'(lo), int'(hi), int'(db));
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        HALF_FRAME = 0; SWEEP_WR = 0; FREQ_LO_WR = 0; FREQ_HI_WR = 0; DB = 8'h00;
        #2 n_RES = 1'b0;
        #1 model_reset();
    endtask

    task automatic release_reset();
        @(negedge CLK);
        n_RES = 1'b1;
    endtask

    typedef struct {
        bit          hf, sw, lo, hi;
        logic [7:0]  db;
        logic [10:0] efreq;
        bit          etick;
        bit          emute;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit hf, input bit sw, input bit lo, input bit hi, input logic [7:0] db,
                       input logic [10:0] efreq, input bit etick, input bit emute);
        vec_t v;
        v.hf = hf; v.sw = sw; v.lo = lo; v.hi = hi; v.db = db;
        v.efreq = efreq; v.etick = etick; v.emute = emute;
        vq.push_back(v);
    endtask

    initial begin
        logic [10:0] neg_res;
        neg_res = (CH == 0) ? 11'h07F : 11'h080;

        // Add sweep, second update
        add(0,0,1,0,8'h00, 11'h000,0,1);
        add(0,0,0,1,8'h01, 11'h100,0,0);
        add(0,1,0,0,8'h81, 11'h100,0,0);
        add(1,0,0,0,8'h00, 11'h180,1,0);
        add(0,0,0,0,8'h00, 11'h180,0,0);
        add(1,0,0,0,8'h00, 11'h240,1,0);
        add(0,0,0,0,8'h00, 11'h240,0,0);
        // Negate
        add(0,0,1,0,8'h00, 11'h200,0,0);
        add(0,0,0,1,8'h01, 11'h100,0,0);
        add(0,1,0,0,8'h89, 11'h100,0,0);
        add(1,0,0,0,8'h00, neg_res,1,0);
        add(0,0,0,0,8'h00, neg_res,0,0);
        // Overflow mute and low-frequency mute
        add(0,0,1,0,8'h00, 11'h000,0,1);
        add(0,0,0,1,8'h06, 11'h600,0,0);
        add(0,1,0,0,8'h81, 11'h600,0,1);
        add(1,0,0,0,8'h00, 11'h600,0,1);
        add(0,0,1,0,8'h07, 11'h607,0,1);
        add(0,0,0,1,8'h00, 11'h007,0,1);
        add(0,1,0,0,8'h89, 11'h007,0,1);
        add(1,0,0,0,8'h00, 11'h007,0,1);
        // Divider period 2
        add(0,0,1,0,8'h00, 11'h000,0,1);
        add(0,0,0,1,8'h01, 11'h100,0,0);
        add(0,1,0,0,8'hA1, 11'h100,0,0);
        add(1,0,0,0,8'h00, 11'h180,1,0);
        add(1,0,0,0,8'h00, 11'h180,0,0);
        add(1,0,0,0,8'h00, 11'h180,0,0);
        add(1,0,0,0,8'h00, 11'h240,1,0);
        add(1,0,0,0,8'h00, 11'h240,0,0);
        add(1,0,0,0,8'h00, 11'h240,0,0);
        add(1,0,0,0,8'h00, 11'h360,1,0);
        // Low-byte write collides with an update
        add(0,1,0,0,8'h81, 11'h360,0,0);
        add(1,0,0,0,8'h00, 11'h360,0,0);
        add(0,0,1,0,8'h00, 11'h300,0,0);
        add(0,0,0,1,8'h01, 11'h100,0,0);
        add(1,0,1,0,8'h55, 11'h155,1,0);
        add(0,0,0,0,8'h00, 11'h155,0,0);
        // Sweep write alongside half-frame uses pre-write settings
        add(1,1,0,0,8'h00, 11'h1FF,1,0);
        add(1,0,0,0,8'h00, 11'h1FF,0,0);

        model_reset();
        n_RES = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset.freq", int'(FREQ), 0);
        chk("reset.sr", int'(SR), 0);
        chk("reset.mute", int'(SWEEP_MUTE), 1);
        chk("reset.tick", int'(SWEEP_TICK), 0);
        chk("reset.shift_err", int'(SHIFT_ERR), 0);
        release_reset();

        for (int i = 0; i < 10; i++) step(1,0,0,0,8'h00);
        chk_model("idle_hf");
        chk("idle_hf.freq0", int'(FREQ), 0);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].hf, vq[i].sw, vq[i].lo, vq[i].hi, vq[i].db);
            chk($sformatf("vec%0d.freq", i), int'(FREQ), int'(vq[i].efreq));
            chk($sformatf("vec%0d.tick", i), int'(SWEEP_TICK), int'(vq[i].etick));
            chk($sformatf("vec%0d.mute", i), int'(SWEEP_MUTE), int'(vq[i].emute));
        end

        // Mid-operation reset must clear a loaded divider
        step(0,1,0,0,8'hF1);
        step(1,0,0,0,8'h00);
        do_reset();
        chk("midrst.freq", int'(FREQ), 0);
        chk("midrst.tick", int'(SWEEP_TICK), 0);
        chk("midrst.mute", int'(SWEEP_MUTE), 1);
        release_reset();
        step(0,0,0,1,8'h01);
        step(0,1,0,0,8'h81);
        step(1,0,0,0,8'h00);
        chk("midrst.upd_freq", int'(FREQ), 'h180);
        chk("midrst.upd_tick", int'(SWEEP_TICK), 1);

        // Randomized run against the model
        for (int i = 0; i < 600; i++) begin
            bit hf, sw, lo, hi;
            logic [7:0] db;
            hf = ($urandom_range(0, 2) == 0);
            sw = ($urandom_range(0, 15) == 0);
            lo = ($urandom_range(0, 11) == 0);
            hi = ($urandom_range(0, 11) == 0);
            db = 8'($urandom);
            if (sw && $urandom_range(0, 3) != 0) db[7] = 1'b1;
            step(hf, sw, lo, hi, db);
            chk_model($sformatf("rnd%0d", i));
        end

        // Shifter self-check with a corrupted S
        step(0,0,1,0,8'h00);
        step(0,0,0,1,8'h01);
        step(0,1,0,0,8'h01);
        chk_model("chk_setup");
        force_s = 1'b1;
        s_force = 11'h000;
        step(0,0,0,0,8'h00);
        chk("shift_err.set", int'(SHIFT_ERR), EXP_ERR);
        force_s = 1'b0;
        step(0,0,0,0,8'h00);
        step(0,0,0,0,8'h00);
        chk("shift_err.sticky", int'(SHIFT_ERR), EXP_ERR);
        do_reset();
        chk("shift_err.reset", int'(SHIFT_ERR), 0);
        release_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
